// File: rtl/canxl_pkg.sv
// Shared CAN XL preface-CRC constants and receive collector state encoding.
// Pure declarations: no latency, no backpressure.
package canxl_pkg;

    localparam int          PCRC_W        = 13;
    localparam logic [12:0] PCRC_POLY     = 13'h1BD;
    localparam logic [12:0] PCRC_INIT     = 13'h0000;
    localparam int          PCRC_HDR_BITS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/crc13_step.sv
// One serial step of the 13-bit preface CRC; purely combinational, zero latency.
// No backpressure: the caller decides when the step result is committed.
module crc13_step
    import canxl_pkg::*;
(
    input  logic [PCRC_W-1:0] crc_in,
    input  logic              din,
    input  logic [PCRC_W-1:0] poly,
    output logic [PCRC_W-1:0] crc_out
);

    logic fb;

    assign fb      = din ^ crc_in[PCRC_W-1];
    assign crc_out = {crc_in[PCRC_W-2:0], 1'b0} ^ (fb ? poly : '0);

endmodule

// File: rtl/pcrc_rx_collector.sv
// Runs the PCRC over the 32 header bits and shifts in the received PCRC field; flag pulses one edge
// after the 13th field bit. No backpressure: bits are consumed on each qualified sample_pt, aborts win.
module pcrc_rx_collector
    import canxl_pkg::*;
#(
    parameter int                CRC_W    = PCRC_W,
    parameter logic [CRC_W-1:0]  POLY     = PCRC_POLY,
    parameter logic [CRC_W-1:0]  INIT     = PCRC_INIT,
    parameter int                HDR_BITS = PCRC_HDR_BITS
) (
    input  logic             clk,
    input  logic             g_rst_n,
    input  logic             sof,
    input  logic             sample_pt,
    input  logic             stuff_bit,
    input  logic             rx_bit,
    input  logic             rx_success,
    input  logic             act_err_frm_tx,
    input  logic             psv_err_frm_tx,
    output logic [CRC_W-1:0] pcrc,
    output logic [CRC_W-1:0] rx_pcrc_frm,
    output logic             rcvd_pcrc_flg,
    output logic             busy
);

    localparam int CNT_W = $clog2(HDR_BITS + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CRC_W-1:0]   pcrc_q, pcrc_d;
    logic [CRC_W-1:0]   frm_q, frm_d;
    logic [CRC_W-1:0]   crc_seed;
    logic [CRC_W-1:0]   crc_next;
    logic               flg_q, flg_d;
    logic               abort;
    logic               qual;

    assign abort   = rx_success | act_err_frm_tx | psv_err_frm_tx;
    assign qual    = sample_pt & ~stuff_bit;
    assign cnt_inc = cnt_q + 1'b1;

    // The SOF bit is folded in on top of INIT in the same cycle the frame opens.
    assign crc_seed = (state_q == IDLE) ? INIT : pcrc_q;

    crc13_step u_crc13_step (
        .crc_in  (crc_seed),
        .din     (rx_bit),
        .poly    (POLY),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcrc_d  = pcrc_q;
        frm_d   = frm_q;
        flg_d   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sof && sample_pt) begin
                        pcrc_d  = crc_next;
                        cnt_d   = CNT_W'(1);
                        frm_d   = '0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    if (qual) begin
                        pcrc_d = crc_next;
                        if (cnt_inc == CNT_W'(HDR_BITS)) begin
                            cnt_d   = '0;
                            state_d = RECV;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                RECV: begin
                    if (qual) begin
                        frm_d = {frm_q[CRC_W-2:0], rx_bit};
                        if (cnt_inc == CNT_W'(CRC_W)) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                DONE: begin
                    flg_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pcrc_q  <= INIT;
            frm_q   <= '0;
            flg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcrc_q  <= pcrc_d;
            frm_q   <= frm_d;
            flg_q   <= flg_d;
        end
    end

    assign pcrc          = pcrc_q;
    assign rx_pcrc_frm   = frm_q;
    assign rcvd_pcrc_flg = flg_q;
    assign busy          = (state_q == CALC) || (state_q == RECV);

endmodule

// File: tb/tb_pcrc_rx_collector.sv
// Directed bench for the PCRC receive collector: clean frames, stuffing, aborts, async reset.
module tb_pcrc_rx_collector;

    logic        clk;
    logic        g_rst_n;
    logic        sof;
    logic        sample_pt;
    logic        stuff_bit;
    logic        rx_bit;
    logic        rx_success;
    logic        act_err_frm_tx;
    logic        psv_err_frm_tx;
    logic [12:0] pcrc;
    logic [12:0] rx_pcrc_frm;
    logic        rcvd_pcrc_flg;
    logic        busy;

    int n_asrt = 0;
    int n_fail = 0;

    pcrc_rx_collector dut (
        .clk            (clk),
        .g_rst_n        (g_rst_n),
        .sof            (sof),
        .sample_pt      (sample_pt),
        .stuff_bit      (stuff_bit),
        .rx_bit         (rx_bit),
        .rx_success     (rx_success),
        .act_err_frm_tx (act_err_frm_tx),
        .psv_err_frm_tx (psv_err_frm_tx),
        .pcrc           (pcrc),
        .rx_pcrc_frm    (rx_pcrc_frm),
        .rcvd_pcrc_flg  (rcvd_pcrc_flg),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial CRC reference written straight from the generator polynomial.
    function automatic logic [12:0] ref_pcrc(input logic [31:0] hdr);
        logic [12:0] r;
        logic        fb;
        r = 13'h0000;
        for (int i = 31; i >= 0; i--) begin
            fb = hdr[i] ^ r[12];
            r  = {r[11:0], 1'b0};
            if (fb) r = r ^ 13'h1BD;
        end
        return r;
    endfunction

    // Drives one sample_pt cycle; inputs change 1 ns after the rising edge.
    task automatic send_bit(input logic b, input logic s, input logic st,
                            input logic ab_act, input logic ab_succ);
        rx_bit         = b;
        sof            = s;
        stuff_bit      = st;
        act_err_frm_tx = ab_act;
        rx_success     = ab_succ;
        sample_pt      = 1'b1;
        @(posedge clk);
        #1;
        sample_pt      = 1'b0;
        sof            = 1'b0;
        stuff_bit      = 1'b0;
        act_err_frm_tx = 1'b0;
        rx_success     = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends the first nbits of a 45-bit frame (32 header + 13 field bits).
    task automatic send_frame(input logic [31:0] hdr, input logic [12:0] fld,
                              input logic stuff_en, input int nbits);
        logic b;
        for (int k = 0; k < nbits; k++) begin
            b = (k < 32) ? hdr[31-k] : fld[12-(k-32)];
            send_bit(b, k == 0, 1'b0, 1'b0, 1'b0);
            if (stuff_en && ((k + 1) % 5 == 0) && (k != 44))
                send_bit(~b, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Flag must be low right after the last bit, high one cycle later, then low again.
    task automatic expect_flag(input string tag);
        @(negedge clk);
        chk({tag, "_flg_t0"}, 32'(rcvd_pcrc_flg), 32'd0);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_flg_t1"}, 32'(rcvd_pcrc_flg), 32'd1);
        @(negedge clk);
        chk({tag, "_flg_t2"}, 32'(rcvd_pcrc_flg), 32'd0);
    endtask

    task automatic expect_no_flag(input string tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(tag, 32'(rcvd_pcrc_flg), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] hdr_mix;
        hdr_mix        = 32'h5A3C_96E1;
        g_rst_n        = 1'b0;
        sof            = 1'b0;
        sample_pt      = 1'b0;
        stuff_bit      = 1'b0;
        rx_bit         = 1'b0;
        rx_success     = 1'b0;
        act_err_frm_tx = 1'b0;
        psv_err_frm_tx = 1'b0;

        #3;
        chk("rst_pcrc", 32'(pcrc), 32'h0);
        chk("rst_frm", 32'(rx_pcrc_frm), 32'h0);
        chk("rst_flg", 32'(rcvd_pcrc_flg), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        idle_cycles(2);
        g_rst_n = 1'b1;
        idle_cycles(2);

        // All-zero header and field.
        send_frame(32'h0000_0000, 13'h0000, 1'b0, 1);
        @(negedge clk);
        chk("zero_busy_calc", 32'(busy), 32'd1);
        idle_cycles(1);
        send_frame(32'h0000_0000, 13'h0000, 1'b0, 0);
        for (int k = 1; k < 45; k++) send_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_flag("zero");
        chk("zero_pcrc", 32'(pcrc), 32'h0);
        chk("zero_frm", 32'(rx_pcrc_frm), 32'h0);
        idle_cycles(2);

        // Single one in the SOF position; 0x15C3 worked by hand.
        send_frame(32'h8000_0000, 13'h1ABC, 1'b0, 45);
        expect_flag("one");
        chk("one_pcrc", 32'(pcrc), 32'h15C3);
        chk("one_frm", 32'(rx_pcrc_frm), 32'h1ABC);
        idle_cycles(3);
        chk("one_hold_pcrc", 32'(pcrc), 32'h15C3);
        chk("one_hold_frm", 32'(rx_pcrc_frm), 32'h1ABC);

        // Same frame with stuff bits and gaps.
        send_frame(32'h8000_0000, 13'h1ABC, 1'b1, 45);
        expect_flag("stuff");
        chk("stuff_pcrc", 32'(pcrc), 32'h15C3);
        chk("stuff_frm", 32'(rx_pcrc_frm), 32'h1ABC);
        idle_cycles(2);

        // Active error frame at header bit 20.
        send_frame(hdr_mix, 13'h0F0F, 1'b0, 20);
        send_bit(hdr_mix[11], 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("abort_hdr_busy", 32'(busy), 32'd0);
        expect_no_flag("abort_hdr_flg");
        send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("abort_hdr_stay_idle", 32'(busy), 32'd0);
        idle_cycles(1);

        // Clean frame after the abort restarts from INIT.
        send_frame(hdr_mix, 13'h0F0F, 1'b0, 45);
        expect_flag("post_abort");
        chk("post_abort_pcrc", 32'(pcrc), 32'(ref_pcrc(hdr_mix)));
        chk("post_abort_frm", 32'(rx_pcrc_frm), 32'h0F0F);
        idle_cycles(2);

        // rx_success together with the 13th field bit discards it.
        send_frame(32'h8000_0000, 13'h1ABC, 1'b0, 44);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("abort_last_busy", 32'(busy), 32'd0);
        expect_no_flag("abort_last_flg");
        chk("abort_last_frm", 32'(rx_pcrc_frm), 32'h0D5E);
        chk("abort_last_pcrc", 32'(pcrc), 32'h15C3);
        idle_cycles(2);

        // Async reset pulse while receiving the field.
        send_frame(32'h8000_0000, 13'h1ABC, 1'b0, 37);
        @(negedge clk);
        chk("arst_busy_before", 32'(busy), 32'd1);
        #2 g_rst_n = 1'b0;
        #1;
        chk("arst_pcrc", 32'(pcrc), 32'h0);
        chk("arst_frm", 32'(rx_pcrc_frm), 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_flg", 32'(rcvd_pcrc_flg), 32'd0);
        #1 g_rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_no_flag("arst_no_flg");
        send_frame(32'h0000_0000, 13'h1ABC, 1'b0, 45);
        expect_flag("arst_next");
        chk("arst_next_pcrc", 32'(pcrc), 32'h0);
        chk("arst_next_frm", 32'(rx_pcrc_frm), 32'h1ABC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/pcrc_rx_collector.md
Name: pcrc_rx_collector

Overview:
- Receive-path stage directly upstream of the PCRC checker.
- Consumes the de-stuffed receive bit stream of a CAN XL frame, running the 13-bit preface CRC serially over the header bits.
- Shifts the transmitted PCRC field into a holding register.
- Presents computed and received values to the checker with a one-cycle rcvd_pcrc_flg strobe.

Parameters:
- CRC_W, 13, CRC width; fixed at 13 for CAN XL and not to be overridden.
- POLY, 13'h1BD, generator polynomial without the implicit x^13 term.
- INIT, 13'h0000, register value loaded at start of frame.
- HDR_BITS, 32, number of protected header bits counted from SOF inclusive.

Ports:
- clk  in  1  system clock
- g_rst_n  in  1  asynchronous active-low reset
- sof  in  1  start-of-frame pulse, coincident with the SOF bit's sample_pt
- sample_pt  in  1  one-cycle strobe marking a valid received bit
- stuff_bit  in  1  current sampled bit is a stuff bit; exclude from CRC and counters
- rx_bit  in  1  sampled bus value
- rx_success  in  1  frame completed; abort/clear
- act_err_frm_tx  in  1  active error frame started; abort/clear
- psv_err_frm_tx  in  1  passive error frame started; abort/clear
- pcrc  out  13  computed PCRC over the header bits
- rx_pcrc_frm  out  13  received PCRC field, MSB first
- rcvd_pcrc_flg  out  1  one-cycle pulse: both values valid
- busy  out  1  high in CALC or RECV

Behaviour:
- Reset values:
  - pcrc = INIT, rx_pcrc_frm = 0.
  - rcvd_pcrc_flg = 0, busy = 0.
  - State IDLE, bit counter = 0.
- Qualified bit: sample_pt && !stuff_bit. Unqualified cycles change nothing except abort handling.
- IDLE:
  - On sof && sample_pt: load pcrc with INIT, then apply the SOF bit in the same cycle.
  - Set counter = 1, clear rx_pcrc_frm, go to CALC.
- CALC:
  - Each qualified bit: fb = rx_bit ^ pcrc[12]; pcrc <= {pcrc[11:0],1'b0} ^ (fb ? POLY : 0); counter++.
  - When counter reaches HDR_BITS after the update, go to RECV with counter = 0.
- RECV:
  - Each qualified bit: rx_pcrc_frm <= {rx_pcrc_frm[11:0], rx_bit}; counter++. pcrc is frozen.
  - On the 13th bit, go to DONE.
- DONE:
  - rcvd_pcrc_flg = 1 for exactly this cycle, then go to IDLE.
  - pcrc and rx_pcrc_frm hold their values until the next sof, so the checker samples stable data.
- Latency: rcvd_pcrc_flg asserts on the clock edge after the one that captured the 13th PCRC bit.
- Abort:
  - Any of rx_success / act_err_frm_tx / psv_err_frm_tx in any state goes to IDLE next cycle with rcvd_pcrc_flg = 0.
  - Abort overrides a simultaneous qualified bit or sof; the bit is discarded.
  - pcrc and rx_pcrc_frm are not cleared on abort.
- sof while busy (resync): ignored unless an abort is also present; frames restart only from IDLE.
- Counter width: clog2(HDR_BITS+1); no wrap is possible in a legal state.
- Async reset mid-frame: all state and outputs return to reset values immediately; no flag is emitted.
- busy deasserts in DONE.

Decomposition:
- Shared package (canxl_pkg):
  - PCRC_W = 13, PCRC_POLY, PCRC_INIT.
  - State enum {IDLE, CALC, RECV, DONE}.
- One natural sub-module, crc13_step: combinational next-state function of (crc_in, bit, POLY). Reused by the transmit-side PCRC generator.

Test Plan:
- All-zero header, INIT = 0:
  - sof + 31 further zero bits, then PCRC field 13'h0000.
  - Required: pcrc = 0, rx_pcrc_frm = 0, single rcvd_pcrc_flg pulse one cycle after the 13th field bit.
- Single-one header, INIT = 0:
  - SOF bit = 1, remaining 31 header bits = 0, then field 13'h1ABC.
  - Required: pcrc matches the bit-serial reference model for this pattern, rx_pcrc_frm = 13'h1ABC, flag pulses once.
- Stuff bits interleaved:
  - Same frame as the previous scenario with a stuff_bit-marked bit after every 5th bit.
  - Required: identical pcrc, rx_pcrc_frm and flag timing relative to the last qualified bit.
- Abort mid-header:
  - act_err_frm_tx asserted at header bit 20.
  - Required: IDLE next cycle, busy = 0, no flag.
  - A following clean frame produces the correct pcrc from INIT.
- Abort coincident with the 13th PCRC bit:
  - rx_success on the same cycle as the last field bit.
  - Required: no rcvd_pcrc_flg, rx_pcrc_frm holds 12 shifted bits.
- Async reset:
  - g_rst_n low for a partial clock period during RECV.
  - Required: outputs at reset values immediately, no flag; the next frame completes normally.
